// File: rtl/imem_pkg.sv
// Shared widths, FSM state type and address field extraction for the
// instruction-fetch cache.
package imem_pkg;

    localparam int IMEM_LINES  = 16;
    localparam int IMEM_WORDS  = 4;
    localparam int IMEM_ADDR_W = 32;

    localparam int OFF_W = $clog2(IMEM_WORDS);
    localparam int IDX_W = $clog2(IMEM_LINES);
    localparam int TAG_W = IMEM_ADDR_W - IDX_W - OFF_W - 2;

    typedef enum logic {
        LOOKUP = 1'b0,
        FILL   = 1'b1
    } imem_state_t;

    function automatic logic [OFF_W-1:0] get_off(input logic [IMEM_ADDR_W-1:0] addr);
        return addr[OFF_W+1:2];
    endfunction

    function automatic logic [IDX_W-1:0] get_idx(input logic [IMEM_ADDR_W-1:0] addr);
        return addr[IDX_W+OFF_W+1:OFF_W+2];
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(input logic [IMEM_ADDR_W-1:0] addr);
        return addr[IMEM_ADDR_W-1:IDX_W+OFF_W+2];
    endfunction

endpackage

// File: rtl/imem_line_store.sv
// Direct-mapped tag/valid/data storage with asynchronous read. Reads and
// writes share one line index because a fill only ever targets the missing line.
module imem_line_store
    import imem_pkg::*;
#(
    parameter int LINES = IMEM_LINES,
    parameter int WORDS = IMEM_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic             clr_en,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             inv_all
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    // Valid-bit update; invalidate-all overrides a line being marked filled.
    always_comb begin
        valid_d = valid_q;
        if (inv_all) begin
            valid_d = {LINES{1'b0}};
        end else if (tag_we) begin
            valid_d[idx] = 1'b1;
        end else if (clr_en) begin
            valid_d[idx] = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only storage that needs a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays, written during a line fill.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[idx][wr_off] <= wr_data;
        end
        if (tag_we) begin
            tag_q[idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx][rd_off];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-side responder: captures the next PC, answers hits one cycle later
// and stalls the front end while a missing line is burst-filled from memory.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int LINES  = IMEM_LINES,
    parameter int WORDS  = IMEM_WORDS,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_en,
    input  logic              inv_all,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              stall,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_rd_valid
);

    imem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_vld_q, req_vld_d;
    logic [OFF_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              inv_pend_q, inv_pend_d;
    logic              mem_rd_req_q, mem_rd_req_d;
    logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;

    logic [IDX_W-1:0]  req_idx_s;
    logic [OFF_W-1:0]  req_off_s;
    logic [TAG_W-1:0]  req_tag_s;
    logic              line_valid_s;
    logic [TAG_W-1:0]  line_tag_s;
    logic [31:0]       line_data_s;
    logic              hit_s;
    logic              miss_s;
    logic              last_beat_s;
    logic              wr_en_s;
    logic              clr_en_s;
    logic              tag_we_s;
    logic              inv_clr_s;
    logic              unused_addr_bits_s;

    assign req_idx_s          = get_idx(req_addr_q);
    assign req_off_s          = get_off(req_addr_q);
    assign req_tag_s          = get_tag(req_addr_q);
    assign unused_addr_bits_s = ^req_addr_q[1:0];
    assign last_beat_s        = mem_rd_valid && (beat_cnt_q == OFF_W'(WORDS - 1));

    imem_line_store #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .idx      (req_idx_s),
        .rd_off   (req_off_s),
        .rd_valid (line_valid_s),
        .rd_tag   (line_tag_s),
        .rd_data  (line_data_s),
        .wr_en    (wr_en_s),
        .wr_off   (beat_cnt_q),
        .wr_data  (mem_rd_data),
        .clr_en   (clr_en_s),
        .tag_we   (tag_we_s),
        .wr_tag   (req_tag_s),
        .inv_all  (inv_clr_s)
    );

    // Hit/miss decode and the combinational fetch response.
    always_comb begin
        hit_s  = (state_q == LOOKUP) && req_vld_q && line_valid_s && (line_tag_s == req_tag_s);
        miss_s = (state_q == LOOKUP) && req_vld_q && !hit_s;
        stall  = (state_q == FILL) || miss_s;
        if (hit_s) begin
            instr       = line_data_s;
            instr_valid = 1'b1;
        end else begin
            instr       = 32'h0000_0000;
            instr_valid = 1'b0;
        end
    end

    // Next-state logic for the capture register, fill FSM and beat counter.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        inv_pend_d    = inv_pend_q;
        mem_rd_req_d  = mem_rd_req_q;
        mem_rd_addr_d = mem_rd_addr_q;
        wr_en_s       = 1'b0;
        clr_en_s      = 1'b0;
        tag_we_s      = 1'b0;
        inv_clr_s     = 1'b0;

        if (!stall) begin
            req_addr_d = fetch_addr;
            req_vld_d  = fetch_en;
        end else begin
            req_addr_d = req_addr_q;
            req_vld_d  = req_vld_q;
        end

        case (state_q)
            LOOKUP: begin
                inv_clr_s = inv_all;
                if (miss_s) begin
                    state_d       = FILL;
                    beat_cnt_d    = {OFF_W{1'b0}};
                    mem_rd_req_d  = 1'b1;
                    mem_rd_addr_d = {req_tag_s, req_idx_s, {OFF_W{1'b0}}, 2'b00};
                end else begin
                    beat_cnt_d = {OFF_W{1'b0}};
                end
            end
            FILL: begin
                if (mem_rd_valid) begin
                    wr_en_s  = 1'b1;
                    // Drop the old line's valid as soon as it starts being overwritten.
                    clr_en_s = (beat_cnt_q == {OFF_W{1'b0}});
                    if (last_beat_s) begin
                        tag_we_s     = 1'b1;
                        inv_clr_s    = inv_pend_q || inv_all;
                        inv_pend_d   = 1'b0;
                        mem_rd_req_d = 1'b0;
                        beat_cnt_d   = {OFF_W{1'b0}};
                        state_d      = LOOKUP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + OFF_W'(1);
                        inv_pend_d = inv_pend_q || inv_all;
                    end
                end else begin
                    inv_pend_d = inv_pend_q || inv_all;
                end
            end
            default: begin
                state_d = LOOKUP;
            end
        endcase
    end

    // All control state, including the registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOOKUP;
            req_addr_q    <= {ADDR_W{1'b0}};
            req_vld_q     <= 1'b0;
            beat_cnt_q    <= {OFF_W{1'b0}};
            inv_pend_q    <= 1'b0;
            mem_rd_req_q  <= 1'b0;
            mem_rd_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            req_vld_q     <= req_vld_d;
            beat_cnt_q    <= beat_cnt_d;
            inv_pend_q    <= inv_pend_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_rd_addr_q <= mem_rd_addr_d;
        end
    end

    assign mem_rd_req  = mem_rd_req_q;
    assign mem_rd_addr = mem_rd_addr_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios then random fetches, checked
// against a tag/valid cache model and a word-addressed backing memory array.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_addr;
    logic        fetch_en;
    logic        inv_all;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] bmem [0:1023];
    bit          m_valid [16];
    logic [23:0] m_tag [16];

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_addr   (fetch_addr),
        .fetch_en     (fetch_en),
        .inv_all      (inv_all),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return bmem[a[11:2]];
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch: hit returns next cycle; a miss is serviced as the memory
    // (gap<0 means random gaps), optionally with inv_all or reset mid-fill.
    task automatic access(input logic [31:0] a, input int gap, input int inv_beat, input int rst_beats);
        logic [31:0] line;
        int          g;
        int          ib;
        bit          inv_seen;
        line       = {a[31:4], 4'h0};
        ib         = inv_beat;
        fetch_addr = a;
        fetch_en   = 1'b1;
        inv_all    = 1'b0;
        tick();
        for (int att = 0; att < 3; att++) begin
            if (m_hit(a)) begin
                chk("hit_stall", 32'(stall), 32'd0);
                chk("hit_valid", 32'(instr_valid), 32'd1);
                chk("hit_instr", instr, memw(a));
                chk("hit_noreq", 32'(mem_rd_req), 32'd0);
                return;
            end
            chk("miss_stall", 32'(stall), 32'd1);
            chk("miss_valid", 32'(instr_valid), 32'd0);
            chk("miss_instr", instr, 32'd0);
            tick();
            chk("fill_req", 32'(mem_rd_req), 32'd1);
            chk("fill_addr", mem_rd_addr, line);
            inv_seen = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (b == rst_beats) begin
                    rst_n        = 1'b0;
                    fetch_en     = 1'b0;
                    mem_rd_valid = 1'b0;
                    #1;
                    chk("rst_req", 32'(mem_rd_req), 32'd0);
                    chk("rst_stall", 32'(stall), 32'd0);
                    chk("rst_valid", 32'(instr_valid), 32'd0);
                    chk("rst_addr", mem_rd_addr, 32'd0);
                    model_clear();
                    tick();
                    tick();
                    rst_n = 1'b1;
                    return;
                end
                if (b == ib) begin
                    inv_all = 1'b1;
                    tick();
                    inv_all  = 1'b0;
                    inv_seen = 1'b1;
                    ib       = -1;
                    chk("inv_fill_stall", 32'(stall), 32'd1);
                end
                g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                for (int k = 0; k < g; k++) begin
                    mem_rd_data = $urandom;
                    tick();
                    chk("gap_req", 32'(mem_rd_req), 32'd1);
                    chk("gap_addr", mem_rd_addr, line);
                    chk("gap_stall", 32'(stall), 32'd1);
                end
                mem_rd_data  = memw(line + 32'(4 * b));
                mem_rd_valid = 1'b1;
                tick();
                mem_rd_valid = 1'b0;
            end
            chk("fill_done_req", 32'(mem_rd_req), 32'd0);
            m_valid[a[7:4]] = 1'b1;
            m_tag[a[7:4]]   = a[31:8];
            if (inv_seen) model_clear();
        end
        chk("access_bound", 32'(att_exhausted(a)), 32'd0);
    endtask

    function automatic bit att_exhausted(input logic [31:0] a);
        return !m_hit(a);
    endfunction

    // inv_all while a hit is being returned: the hit still shows this cycle.
    task automatic pulse_inv();
        inv_all = 1'b1;
        chk("inv_lookup_hit", 32'(instr_valid), 32'(m_hit(fetch_addr)));
        fetch_en = 1'b0;
        tick();
        inv_all = 1'b0;
        model_clear();
        chk("inv_idle_stall", 32'(stall), 32'd0);
        chk("inv_idle_valid", 32'(instr_valid), 32'd0);
    endtask

    task automatic idle();
        fetch_en = 1'b0;
        tick();
        chk("idle_valid", 32'(instr_valid), 32'd0);
        chk("idle_instr", instr, 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_req", 32'(mem_rd_req), 32'd0);
        mem_rd_data  = $urandom;
        mem_rd_valid = 1'b1;
        tick();
        mem_rd_valid = 1'b0;
        chk("stray_req", 32'(mem_rd_req), 32'd0);
        chk("stray_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        rst_n        = 1'b0;
        fetch_addr   = 32'd0;
        fetch_en     = 1'b0;
        inv_all      = 1'b0;
        mem_rd_data  = 32'd0;
        mem_rd_valid = 1'b0;
        for (int i = 0; i < 1024; i++) bmem[i] = $urandom;
        bmem[16] = 32'h11; bmem[17] = 32'h22; bmem[18] = 32'h33; bmem[19] = 32'h44;
        bmem[80] = 32'hA0; bmem[81] = 32'hA1; bmem[82] = 32'hA2; bmem[83] = 32'hA3;
        model_clear();

        tick();
        tick();
        chk("reset_instr", instr, 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_req", 32'(mem_rd_req), 32'd0);
        chk("reset_addr", mem_rd_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        access(32'h40, 0, -1, -1);
        chk("cold_instr", instr, 32'h11);
        access(32'h44, 0, -1, -1);
        access(32'h48, 0, -1, -1);
        access(32'h4C, 0, -1, -1);
        chk("hit_last_instr", instr, 32'h44);
        access(32'h140, 0, -1, -1);
        chk("evict_instr", instr, 32'hA0);
        access(32'h40, 0, -1, -1);
        access(32'h140, 2, 1, -1);
        access(32'h40, 0, -1, 2);
        access(32'h40, 0, -1, -1);
        idle();
        idle();
        access(32'h40, 0, -1, -1);
        chk("post_stray_instr", instr, 32'h11);
        pulse_inv();
        access(32'h40, 0, -1, -1);

        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63)) << 2;
            else a = 32'($urandom_range(0, 1023)) << 2;
            if (r == 0) begin
                idle();
            end else if (r == 1) begin
                access(a, -1, -1, int'($urandom_range(0, 3)));
            end else if (r == 2) begin
                access(a, -1, -1, -1);
                pulse_inv();
            end else if (r == 3) begin
                access(a, -1, int'($urandom_range(0, 3)), -1);
            end else begin
                access(a, -1, -1, -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
